// File: rtl/fsm_bist_ctrl.sv
// BIST wrapper for the 4-bit Moore FSM: LFSR stimulus in, MISR signature out, golden compare.
// Define FSM_BIST_SIG_OUT_EN to expose the live MISR on signature_o (otherwise it reads 0).
module fsm_bist_ctrl #(
    parameter int unsigned PATTERN_CNT = 255,
    parameter logic [4:0]  LFSR_SEED   = 5'b00001,
    parameter logic [15:0] GOLDEN_SIG  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bist_req,
    input  logic [3:0]  sig_func_i,
    input  logic [3:0]  state_i,
    output logic [3:0]  sig_o,
    output logic        start_bist_o,
    output logic        bist_busy_o,
    output logic        bist_done_o,
    output logic        bist_pass_o,
    output logic [15:0] signature_o
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        RUN,
        FLUSH,
        DONE
    } bistState_e;

    localparam logic [8:0] LAST_CNT = 9'(PATTERN_CNT - 1);

    bistState_e  state_q, state_d;
    logic        reqDly_q;
    logic        armed_q;
    logic [4:0]  lfsr_q, lfsr_d;
    logic [15:0] misr_q, misr_d;
    logic [15:0] misrNext;
    logic [8:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        busy_q, busy_d;
    logic        startBist_q, startBist_d;
    logic        startCond;

    // A request level already high when reset releases is not a rising edge,
    // so starts are held off until reqDly_q has sampled bist_req once.
    assign startCond = bist_req & ~reqDly_q & armed_q;

    assign misrNext = {misr_q[14:0], 1'b0}
                    ^ (misr_q[15] ? 16'h1021 : 16'h0000)
                    ^ {12'h000, state_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            reqDly_q    <= 1'b0;
            armed_q     <= 1'b0;
            lfsr_q      <= LFSR_SEED;
            misr_q      <= 16'hFFFF;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            busy_q      <= 1'b0;
            startBist_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            reqDly_q    <= bist_req;
            armed_q     <= 1'b1;
            lfsr_q      <= lfsr_d;
            misr_q      <= misr_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            busy_q      <= busy_d;
            startBist_q <= startBist_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        misr_d  = misr_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE, DONE: begin
                if (startCond) begin
                    state_d = INIT;
                    lfsr_d  = LFSR_SEED;
                    misr_d  = 16'hFFFF;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            INIT: begin
                state_d = RUN;
            end
            RUN: begin
                lfsr_d = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
                misr_d = misrNext;
                cnt_d  = cnt_q + 9'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                misr_d  = misrNext;
                state_d = DONE;
                done_d  = 1'b1;
                pass_d  = (misrNext == GOLDEN_SIG);
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // FSM-facing strobes are registered from the next state so they never glitch.
        busy_d      = (state_d == INIT) || (state_d == RUN) || (state_d == FLUSH);
        startBist_d = (state_d == INIT) || (state_d == FLUSH);
    end

    assign sig_o        = busy_q ? lfsr_q[3:0] : sig_func_i;
    assign start_bist_o = startBist_q;
    assign bist_busy_o  = busy_q;
    assign bist_done_o  = done_q;
    assign bist_pass_o  = pass_q;

`ifdef FSM_BIST_SIG_OUT_EN
    assign signature_o = misr_q;
`else
    assign signature_o = 16'h0000;
`endif

endmodule

// File: tb/tb_fsm_bist_ctrl.sv
// Self-checking bench for fsm_bist_ctrl: constant vectors, hand-written run sequences and
// randomized traffic checked against a run-timeline reference model.
module tb_fsm_bist_ctrl;

    localparam int          PCNT = 4;
    localparam logic [4:0]  SEED = 5'b00001;
    localparam logic [15:0] GOLD = 16'h1C00;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        bist_req   = 1'b0;
    logic [3:0]  sig_func_i = 4'h0;
    logic [3:0]  state_i    = 4'h0;
    logic [3:0]  sig_o;
    logic        start_bist_o;
    logic        bist_busy_o;
    logic        bist_done_o;
    logic        bist_pass_o;
    logic [15:0] signature_o;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: k counts clock edges since the accepted start edge
    // (0 = no run since reset, 1 = INIT, 2..PCNT+1 = RUN, PCNT+2 = FLUSH, beyond = done).
    int         k        = 0;
    bit         reqPrev  = 1'b0;
    bit         reqKnown = 1'b0;
    logic [3:0] captured[$];
    logic [3:0] lfsrTab[31];

    typedef struct {
        logic [3:0] func;
        logic [3:0] expSig;
    } vec_t;

    fsm_bist_ctrl #(
        .PATTERN_CNT(PCNT),
        .LFSR_SEED  (SEED),
        .GOLDEN_SIG (GOLD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bist_req    (bist_req),
        .sig_func_i  (sig_func_i),
        .state_i     (state_i),
        .sig_o       (sig_o),
        .start_bist_o(start_bist_o),
        .bist_busy_o (bist_busy_o),
        .bist_done_o (bist_done_o),
        .bist_pass_o (bist_pass_o),
        .signature_o (signature_o)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] misrFold();
        logic [15:0] m;
        m = 16'hFFFF;
        foreach (captured[i]) begin
            m = {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000) ^ {12'h000, captured[i]};
        end
        return m;
    endfunction

    task automatic modelReset();
        k        = 0;
        reqPrev  = 1'b0;
        reqKnown = 1'b0;
        captured.delete();
    endtask

    task automatic modelEdge();
        bit busyNow;
        bit start;
        busyNow = (k >= 1) && (k <= PCNT + 2);
        start   = bist_req && reqKnown && !reqPrev && !busyNow;
        if (start) begin
            k = 1;
            captured.delete();
        end else if (busyNow) begin
            if (k >= 2) captured.push_back(state_i);
            k++;
        end
        reqPrev  = bist_req;
        reqKnown = 1'b1;
    endtask

    task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        logic        busyE, startE, doneE, passE;
        logic [3:0]  sigE;
        logic [15:0] sigOutE;
        int          idx;
        busyE  = (k >= 1) && (k <= PCNT + 2);
        startE = (k == 1) || (k == PCNT + 2);
        doneE  = (k >= PCNT + 3);
        passE  = doneE && (misrFold() == GOLD);
        idx    = ((k < 2) ? 0 : k - 2) % 31;
        sigE   = busyE ? lfsrTab[idx[4:0]] : sig_func_i;
`ifdef FSM_BIST_SIG_OUT_EN
        sigOutE = misrFold();
`else
        sigOutE = 16'h0000;
`endif
        checkVal("sig_o", 16'(sig_o), 16'(sigE));
        checkVal("start_bist_o", 16'(start_bist_o), 16'(startE));
        checkVal("bist_busy_o", 16'(bist_busy_o), 16'(busyE));
        checkVal("bist_done_o", 16'(bist_done_o), 16'(doneE));
        checkVal("bist_pass_o", 16'(bist_pass_o), 16'(passE));
        checkVal("signature_o", signature_o, sigOutE);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) modelEdge();
        #2;
    endtask

    task automatic applyStimulus(input logic req, input logic [3:0] func, input logic [3:0] st);
        bist_req   = req;
        sig_func_i = func;
        state_i    = st;
        #1;
    endtask

    task automatic setReset(input logic level);
        rst_n = level;
        if (!level) modelReset();
        #1;
    endtask

    task automatic runBist(input logic [3:0] lastState, input bit wiggleReq,
                           input logic expPass, input logic [15:0] expSignature);
        logic [3:0]  resp[5];
        logic [3:0]  runSig[4];
        logic        req;
        logic [15:0] sigOutE;
        resp   = '{4'h0, 4'h2, 4'h9, 4'h0, lastState};
        runSig = '{4'h1, 4'h2, 4'h4, 4'h9};
`ifdef FSM_BIST_SIG_OUT_EN
        sigOutE = expSignature;
`else
        sigOutE = 16'h0000;
`endif
        applyStimulus(1'b0, 4'h6, 4'h0);
        checkOutput();
        cycle();
        applyStimulus(1'b1, 4'h6, 4'h0);
        checkOutput();
        cycle();
        applyStimulus(1'b1, 4'h6, 4'h0);
        checkOutput();
        checkVal("initStartBist", 16'(start_bist_o), 16'h0001);
        checkVal("initDoneClear", 16'(bist_done_o), 16'h0000);
        checkVal("initPassClear", 16'(bist_pass_o), 16'h0000);
        cycle();
        for (int i = 0; i < 5; i++) begin
            req = wiggleReq ? logic'(i % 2) : 1'b1;
            applyStimulus(req, 4'h6, resp[i]);
            checkOutput();
            if (i < 4) checkVal("runSig", 16'(sig_o), 16'(runSig[i]));
            checkVal("busyDuringRun", 16'(bist_busy_o), 16'h0001);
            checkVal("doneNotEarly", 16'(bist_done_o), 16'h0000);
            cycle();
        end
        for (int j = 0; j < 2; j++) begin
            applyStimulus(1'b0, 4'h6, 4'h0);
            checkOutput();
            checkVal("doneAtE6", 16'(bist_done_o), 16'h0001);
            checkVal("passResult", 16'(bist_pass_o), 16'(expPass));
            checkVal("finalSignature", signature_o, sigOutE);
            checkVal("idleAfterDone", 16'(bist_busy_o), 16'h0000);
            cycle();
        end
    endtask

    initial begin
        vec_t        vecs[6];
        logic [4:0]  v;
        logic [15:0] resetSig;

        v = SEED;
        for (int i = 0; i < 31; i++) begin
            lfsrTab[i] = v[3:0];
            v = {v[3:0], v[4] ^ v[2]};
        end
        captured.delete();
`ifdef FSM_BIST_SIG_OUT_EN
        resetSig = 16'hFFFF;
`else
        resetSig = 16'h0000;
`endif

        vecs[0] = '{func: 4'hA, expSig: 4'hA};
        vecs[1] = '{func: 4'h0, expSig: 4'h0};
        vecs[2] = '{func: 4'hF, expSig: 4'hF};
        vecs[3] = '{func: 4'h5, expSig: 4'h5};
        vecs[4] = '{func: 4'h3, expSig: 4'h3};
        vecs[5] = '{func: 4'hC, expSig: 4'hC};

        // Reset held with the request already high.
        setReset(1'b0);
        applyStimulus(1'b1, 4'h5, 4'h0);
        cycle();
        cycle();
        checkOutput();
        checkVal("rstBusy", 16'(bist_busy_o), 16'h0000);
        checkVal("rstStart", 16'(start_bist_o), 16'h0000);
        checkVal("rstDone", 16'(bist_done_o), 16'h0000);
        checkVal("rstPass", 16'(bist_pass_o), 16'h0000);
        checkVal("rstSigPass", 16'(sig_o), 16'h0005);
        checkVal("rstSignature", signature_o, resetSig);
        setReset(1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle();
            checkOutput();
            checkVal("noRunAfterReset", 16'(bist_busy_o), 16'h0000);
        end

        applyStimulus(1'b0, 4'h0, 4'h0);
        cycle();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, vecs[i].func, 4'($urandom));
            checkOutput();
            checkVal("passthroughSig", 16'(sig_o), 16'(vecs[i].expSig));
            checkVal("passthroughStart", 16'(start_bist_o), 16'h0000);
            cycle();
        end

        runBist(4'hA, 1'b0, 1'b1, 16'h1C00);
        runBist(4'hB, 1'b0, 1'b0, 16'h1C01);
        runBist(4'hA, 1'b1, 1'b1, 16'h1C00);

        // Reset asserted in the second RUN cycle.
        applyStimulus(1'b0, 4'h7, 4'h0);
        cycle();
        applyStimulus(1'b1, 4'h7, 4'h0);
        cycle();
        cycle();
        applyStimulus(1'b1, 4'h7, 4'h0);
        cycle();
        applyStimulus(1'b1, 4'h7, 4'h2);
        checkOutput();
        setReset(1'b0);
        checkOutput();
        checkVal("midRstBusy", 16'(bist_busy_o), 16'h0000);
        checkVal("midRstSignature", signature_o, resetSig);
        checkVal("midRstSig", 16'(sig_o), 16'h0007);
        cycle();
        setReset(1'b1);
        runBist(4'hA, 1'b0, 1'b1, 16'h1C00);

        for (int c = 0; c < 3000; c++) begin
            if (!rst_n) begin
                if ($urandom_range(0, 2) == 0) setReset(1'b1);
            end else if ($urandom_range(0, 399) == 0) begin
                setReset(1'b0);
            end
            applyStimulus(($urandom_range(0, 5) == 0) ? ~bist_req : bist_req,
                          4'($urandom), 4'($urandom));
            checkOutput();
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
